// File: rtl/ps_pkg.sv
// ps_pkg: constants and types shared by the ps_ pixel-stream stages.
//   DATA_WIDTH     pixel width, RGB444 packed as {R[11:8], G[7:4], B[3:0]}
//   FRAME_PIXELS   pixels per 640x480 frame
//   LUMA_*         integer luma weights; Y = (5R + 9G + 2B) >> 4 fits 0..15
//   state_t        control state of a stage (RUN / FLUSH)
package ps_pkg;

  localparam int DATA_WIDTH   = 12;
  localparam int FRAME_PIXELS = 307200;

  // Weights sum to 16, so the full-scale intermediate is 15 * 16 = 240 and
  // an 8-bit accumulator never overflows.
  localparam int              LUMA_W     = 8;
  localparam logic [LUMA_W-1:0] LUMA_CR  = 8'd5;
  localparam logic [LUMA_W-1:0] LUMA_CG  = 8'd9;
  localparam logic [LUMA_W-1:0] LUMA_CB  = 8'd2;
  localparam int              LUMA_SHIFT = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/ps_sync_fifo.sv
// ps_sync_fifo: single-clock FIFO used as the output buffer of ps_ stages.
//   clk, rst       clock; synchronous active-high reset
//   clr            synchronous clear of pointers and fill (data kept)
//   wr, wr_data    write strobe and data; ignored while full
//   rd, rd_data    read strobe; rd_data is registered, valid the cycle after rd;
//                  a read while empty is ignored and rd_data holds
//   fill           occupancy 0..DEPTH
//   full / almostfull / empty / almostempty
//                  fill==DEPTH / fill>=DEPTH-AFULL_MARGIN / fill==0 / fill<=1
// DEPTH must be a power of two so the pointers wrap naturally.
module ps_sync_fifo #(
  parameter  int WIDTH        = 12,
  parameter  int DEPTH        = 1024,
  parameter  int AFULL_MARGIN = 4,
  localparam int AW           = $clog2(DEPTH),
  localparam int FW           = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic [FW-1:0]    fill,
  output logic             full,
  output logic             almostfull,
  output logic             empty,
  output logic             almostempty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  assign empty       = (fill == '0);
  assign almostempty = (fill <= FW'(1));
  assign full        = (fill == FW'(DEPTH));
  assign almostfull  = (fill >= FW'(DEPTH - AFULL_MARGIN));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Read data is the only datapath register with a reset, so the output
  // port shows zero rather than stale memory after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_ok && !clr) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/ps_threshold_top.sv
// ps_threshold_top: binary-threshold stage between the Sobel output FIFO and
// the frame-buffer interface.
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_enable            1 = binarize on luma, 0 = pass pixel through
//   i_flush             synchronous flush of pipeline, counter and output FIFO
//   i_level             luma threshold 0..15 (0 makes every pixel white)
//   i_data              upstream FIFO data, valid the cycle after o_rd
//   i_almostempty       upstream FIFO holds at most one word
//   o_rd                upstream read strobe
//   i_obuf_rd           output FIFO read strobe
//   o_obuf_data         output FIFO data, valid the cycle after i_obuf_rd
//   o_obuf_fill         output FIFO occupancy
//   o_obuf_full / o_obuf_almostfull / o_obuf_empty / o_obuf_almostempty
//   o_frame_done        one-cycle pulse on the write of the last pixel of a frame
module ps_threshold_top #(
  parameter  int DATA_WIDTH   = ps_pkg::DATA_WIDTH,
  parameter  int FIFO_DEPTH   = 1024,
  parameter  int FRAME_PIXELS = ps_pkg::FRAME_PIXELS,
  localparam int FILL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [3:0]            i_level,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_almostempty,
  output logic                  o_rd,
  input  logic                  i_obuf_rd,
  output logic [DATA_WIDTH-1:0] o_obuf_data,
  output logic [FILL_W-1:0]     o_obuf_fill,
  output logic                  o_obuf_full,
  output logic                  o_obuf_almostfull,
  output logic                  o_obuf_empty,
  output logic                  o_obuf_almostempty,
  output logic                  o_frame_done
);

  import ps_pkg::*;

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  function automatic logic [3:0] luma(input logic [DATA_WIDTH-1:0] px);
    logic [LUMA_W-1:0] acc;
    acc = LUMA_CR * {4'b0000, px[11:8]}
        + LUMA_CG * {4'b0000, px[7:4]}
        + LUMA_CB * {4'b0000, px[3:0]};
    return 4'(acc >> LUMA_SHIFT);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] binarize(input logic [3:0] y,
                                                     input logic [3:0] lvl);
    return (y >= lvl) ? '1 : '0;
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic                    flush_now;
  logic                    vld_p1;
  logic                    vld_p2;
  logic [DATA_WIDTH-1:0]   data_p2;
  logic                    wr_en;
  logic [CNT_W-1:0]        pix_cnt;
  logic                    frame_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // The read strobe is gated by i_flush directly so it drops in the very
  // cycle the flush request appears, before the state register follows.
  always_comb begin
    state_nxt = state;
    flush_now = 1'b0;
    o_rd      = 1'b0;
    case (state)
      RUN: begin
        if (i_flush) begin
          state_nxt = FLUSH;
          flush_now = 1'b1;
        end else begin
          o_rd = !i_almostempty && !o_obuf_almostfull;
        end
      end
      FLUSH: begin
        flush_now = 1'b1;
        if (!i_flush) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (i_rst) begin
      o_rd = 1'b0;
    end
  end

  // Stage 1: upstream word arrives on i_data while vld_p1 is set.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush_now) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= o_rd;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 2: processed pixel registered; mode and level taken from this cycle.
  always_ff @(posedge i_clk) begin
    if (vld_p1) begin
      data_p2 <= i_enable ? binarize(luma(i_data), i_level) : i_data;
    end
  end

  // A word still in stage 2 when a flush or reset hits is dropped here.
  assign wr_en        = vld_p2 && !flush_now && !i_rst && !o_obuf_full;
  assign frame_last   = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign o_frame_done = wr_en && frame_last;

  always_ff @(posedge i_clk) begin
    if (i_rst || flush_now) begin
      pix_cnt <= '0;
    end else if (wr_en) begin
      pix_cnt <= frame_last ? '0 : pix_cnt + 1'b1;
    end
  end

  ps_sync_fifo #(
    .WIDTH        (DATA_WIDTH),
    .DEPTH        (FIFO_DEPTH),
    .AFULL_MARGIN (4)
  ) u_obuf (
    .clk         (i_clk),
    .rst         (i_rst),
    .clr         (flush_now),
    .wr          (wr_en),
    .wr_data     (data_p2),
    .rd          (i_obuf_rd),
    .rd_data     (o_obuf_data),
    .fill        (o_obuf_fill),
    .full        (o_obuf_full),
    .almostfull  (o_obuf_almostfull),
    .empty       (o_obuf_empty),
    .almostempty (o_obuf_almostempty)
  );

endmodule

// File: tb/tb_ps_threshold_top.sv
// tb_ps_threshold_top: directed bench for ps_threshold_top. Models the
// upstream FIFO as a queue with one-cycle read latency and drains the output
// FIFO from a negedge process; frame length is shortened to keep runs short.
module tb_ps_threshold_top;

  localparam int DW       = 12;
  localparam int DEPTH    = 1024;
  localparam int TB_FRAME = 1000;
  localparam int FW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [3:0]    level = 4'd0;
  logic [DW-1:0] data = '0;
  logic          almostempty = 1'b1;
  logic          rd;
  logic          obuf_rd = 1'b0;
  logic [DW-1:0] obuf_data;
  logic [FW-1:0] fill;
  logic          obuf_full, obuf_almostfull, obuf_empty, obuf_almostempty;
  logic          frame_done;

  always #5 clk = ~clk;

  ps_threshold_top #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .FRAME_PIXELS (TB_FRAME)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_enable           (enable),
    .i_flush            (flush),
    .i_level            (level),
    .i_data             (data),
    .i_almostempty      (almostempty),
    .o_rd               (rd),
    .i_obuf_rd          (obuf_rd),
    .o_obuf_data        (obuf_data),
    .o_obuf_fill        (fill),
    .o_obuf_full        (obuf_full),
    .o_obuf_almostfull  (obuf_almostfull),
    .o_obuf_empty       (obuf_empty),
    .o_obuf_almostempty (obuf_almostempty),
    .o_frame_done       (frame_done)
  );

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] out_q[$];
  int            cyc_q[$];
  int            cyc = 0;
  logic          drain_en = 1'b0;
  logic          rd_prev = 1'b0;
  int            wr_count = 0;
  int            fd_count = 0;
  int            fd_idx = -1;
  int            ovf_events = 0;
  int            af_events = 0;
  int            n_checks = 0;
  int            n_err = 0;

  // Upstream FIFO: registered read data, one cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd && src_q.size() > 0) begin
      data <= src_q.pop_front();
    end
  end

  // Monitors and output-side driver, all away from the active edge.
  always @(negedge clk) begin
    if (dut.vld_p2 && obuf_full) ovf_events++;
    if (obuf_almostfull && rd) af_events++;
    if (frame_done) begin
      fd_count++;
      fd_idx = wr_count;
    end
    if (dut.wr_en) wr_count++;
    if (rd_prev) begin
      out_q.push_back(obuf_data);
      cyc_q.push_back(cyc);
    end
    almostempty = (src_q.size() <= 1);
    obuf_rd = drain_en && !obuf_empty;
    rd_prev = obuf_rd;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    drain_en = 1'b0;
    flush = 1'b0;
    src_q.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    out_q.delete();
    cyc_q.delete();
    wr_count = 0;
    fd_count = 0;
    fd_idx = -1;
    rst = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, out_q.size(), n);
  endtask

  initial begin
    int bad;
    int n_rem;
    logic [DW-1:0] exp_next;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd", rd, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_obuf_data", obuf_data, 0);
    check("rst_fill", fill, 0);
    check("rst_empty", obuf_empty, 1);
    check("rst_almostempty", obuf_almostempty, 1);
    check("rst_full", obuf_full, 0);
    check("rst_almostfull", obuf_almostfull, 0);
    check("rst_counter", dut.pix_cnt, 0);
    check("rst_state", dut.state, ps_pkg::RUN);

    // Threshold, level 8: Y(888)=128>>4=8, Y(777)=7, Y(F00)=75>>4=4, Y(0F0)=135>>4=8
    restart();
    enable = 1'b1;
    level = 4'd8;
    src_q.push_back(12'h888);
    src_q.push_back(12'h777);
    src_q.push_back(12'hF00);
    src_q.push_back(12'h0F0);
    src_q.push_back(12'h000);
    drain_en = 1'b1;
    wait_out("thr_count", 4, 60);
    check("thr_888", out_q[0], 12'hFFF);
    check("thr_777", out_q[1], 12'h000);
    check("thr_F00", out_q[2], 12'h000);
    check("thr_0F0", out_q[3], 12'hFFF);
    // Level 0: the parked 000 word becomes white
    level = 4'd0;
    src_q.push_back(12'h001);
    wait_out("thr_l0_count", 5, 60);
    check("thr_l0_000", out_q[4], 12'hFFF);
    // Level 15: Y(001)=0, Y(FFF)=240>>4=15, Y(EEE)=224>>4=14
    level = 4'd15;
    src_q.push_back(12'hFFF);
    src_q.push_back(12'hEEE);
    src_q.push_back(12'h000);
    wait_out("thr_l15_count", 8, 60);
    check("thr_l15_001", out_q[5], 12'h000);
    check("thr_l15_FFF", out_q[6], 12'hFFF);
    check("thr_l15_EEE", out_q[7], 12'h000);

    // Pass-through ramp at one pixel per cycle
    restart();
    enable = 1'b0;
    for (int i = 0; i < 4096; i++) src_q.push_back(DW'(i));
    src_q.push_back(12'h000);
    drain_en = 1'b1;
    wait_out("ramp_count", 4096, 5000);
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 4096; i++)
      if (out_q[i] !== DW'(i)) bad++;
    check("ramp_mismatches", bad, 0);
    check("ramp_last", out_q[4095], 12'hFFF);
    check("ramp_span_cycles", cyc_q[4095] - cyc_q[0], 4095);

    // Backpressure: never read until the stage stalls, then drain
    restart();
    enable = 1'b0;
    for (int i = 0; i < 1100; i++) src_q.push_back(DW'(i));
    repeat (1200) @(negedge clk);
    check("bp_fill_in_range", (fill >= FW'(1020)) && (fill <= FW'(1024)), 1);
    check("bp_rd_stalled", rd, 0);
    check("bp_almostfull", obuf_almostfull, 1);
    drain_en = 1'b1;
    wait_out("bp_count", 1099, 3000);
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 1099; i++)
      if (out_q[i] !== DW'(i)) bad++;
    check("bp_mismatches", bad, 0);
    repeat (20) @(negedge clk);
    check("bp_no_extra", out_q.size(), 1099);

    // Flush with 50 words buffered and reads in flight
    restart();
    enable = 1'b0;
    for (int i = 0; i < 200; i++) src_q.push_back(DW'(12'h200 + i));
    bad = 0;
    while (fill != FW'(50) && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    check("fl_fill50", fill, 50);
    check("fl_read_in_flight", rd, 1);
    flush = 1'b1;
    exp_next = src_q[0];
    n_rem = src_q.size();
    @(negedge clk);
    check("fl_fill_zero", fill, 0);
    check("fl_empty", obuf_empty, 1);
    check("fl_rd_low", rd, 0);
    check("fl_counter_zero", dut.pix_cnt, 0);
    repeat (2) @(negedge clk);
    flush = 1'b0;
    drain_en = 1'b1;
    wait_out("fl_count", n_rem - 1, 500);
    check("fl_first_after", out_q[0], exp_next);
    check("fl_no_frame_done", fd_count, 0);
    check("fl_counter_restart", dut.pix_cnt, n_rem - 1);

    // Reset mid-stream with about 10 words in flight
    restart();
    enable = 1'b0;
    for (int i = 0; i < 30; i++) src_q.push_back(DW'(12'h300 + i));
    repeat (12) @(negedge clk);
    rst = 1'b1;
    exp_next = src_q[0];
    n_rem = src_q.size();
    @(negedge clk);
    check("mr_rd", rd, 0);
    check("mr_fill", fill, 0);
    check("mr_empty", obuf_empty, 1);
    check("mr_counter", dut.pix_cnt, 0);
    rst = 1'b0;
    drain_en = 1'b1;
    wait_out("mr_count", n_rem - 1, 200);
    check("mr_first_after", out_q[0], exp_next);

    // Frame boundary: TB_FRAME + 5 pixels
    restart();
    enable = 1'b0;
    for (int i = 0; i < TB_FRAME + 6; i++) src_q.push_back(DW'(i));
    drain_en = 1'b1;
    wait_out("fr_count", TB_FRAME + 5, 1500);
    repeat (2) @(negedge clk);
    check("fr_pulses", fd_count, 1);
    check("fr_pulse_index", fd_idx, TB_FRAME - 1);
    check("fr_counter_after", dut.pix_cnt, 5);

    check("no_write_while_full", ovf_events, 0);
    check("no_rd_while_almostfull", af_events, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ps_threshold_top.md
# ps_threshold_top

Binary-threshold pipeline stage placed directly downstream of the Sobel stage and upstream of the frame-buffer memory interface. It pulls 12-bit RGB444 pixels from the Sobel output FIFO using the almost-empty/read handshake. When enabled, each pixel is reduced to a 4-bit luma value and compared against a run-time level, producing pure white or black; when disabled, pixels pass through unchanged. Results are buffered in an internal output FIFO with the same read interface as every other stage, and the block counts pixels per frame so it can flag frame completion.

## Interface
- DATA_WIDTH, 12, pixel width; {R[11:8], G[7:4], B[3:0]}
- FIFO_DEPTH, 1024, output FIFO entries; power of two
- FRAME_PIXELS, 307200, pixels per frame (640x480)
- i_clk  in  1  processing clock (125 MHz)
- i_rst  in  1  synchronous reset, active-high
- i_enable  in  1  1 = threshold, 0 = pass-through
- i_flush  in  1  synchronous pipeline flush
- i_level  in  4  luma threshold, 0..15
- i_data  in  12  upstream FIFO read data, valid the cycle after o_rd
- i_almostempty  in  1  upstream FIFO holds ≤1 word
- o_rd  out  1  upstream FIFO read strobe
- i_obuf_rd  in  1  output FIFO read strobe
- o_obuf_data  out  12  output FIFO data, valid the cycle after i_obuf_rd
- o_obuf_fill  out  log2(FIFO_DEPTH)+1  output FIFO occupancy
- o_obuf_full / o_obuf_almostfull / o_obuf_empty / o_obuf_almostempty  out  1 each  FIFO flags
- o_frame_done  out  1  one-cycle pulse when the FRAME_PIXELS-th pixel of a frame is written

## Operation
- FSM states: RUN and FLUSH. Reset enters RUN. i_flush=1 enters FLUSH from any state. FLUSH returns to RUN on the first cycle with i_flush=0.
- In FLUSH:
  - o_rd=0.
  - The pipeline valid bit, the pixel counter and the output FIFO pointers are cleared; fill=0.
  - An i_data word arriving from a read issued before the flush is discarded.
- In RUN, o_rd = !i_almostempty && !o_obuf_almostfull.
- Stage 1: the valid bit registers o_rd.
- Stage 2: with valid=1, the computed pixel is registered, along with the write enable.
- Luma computation:
  - Y = (5·R + 9·G + 2·B) >> 4, with an 8-bit intermediate; maximum 240, so Y ranges 0..15.
  - Output = 12'hFFF if Y ≥ i_level, else 12'h000. A level of 0 gives all white.
- Pass-through: output = i_data.
- i_enable and i_level are sampled on the same cycle the word is in stage 1; no per-frame latching.
- Pixel counter:
  - Range 0..FRAME_PIXELS-1; increments on each FIFO write.
  - On a write at FRAME_PIXELS-1, the counter wraps to 0 and o_frame_done pulses in the same cycle as the write.
- Output FIFO flags:
  - empty: fill=0.
  - almostempty: fill≤1.
  - full: fill=FIFO_DEPTH.
  - almostfull: fill≥FIFO_DEPTH-4, which covers 2 words in flight plus margin.
- A write while full and a read while empty are ignored. The bench checks they never occur under the handshake.
- A simultaneous read and write leaves fill unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - o_rd=0, o_frame_done=0, o_obuf_data=0, fill=0.
  - o_obuf_empty=1, o_obuf_almostempty=1, o_obuf_full=0, o_obuf_almostfull=0.
  - Counter=0; state RUN.
- Reset has priority over flush.
- Latency:
  - o_rd at cycle N → i_data at N+1 → FIFO write at N+2, with fill incremented by N+3.
  - i_obuf_rd at M → o_obuf_data valid at M+1.
- Throughput: 1 pixel/cycle sustained while the upstream FIFO holds ≥2 words and the output FIFO is not almost full.
- Flush: o_rd drops in the same cycle i_flush rises, because it is gated combinationally by state/flush. The FIFO reads empty from the next cycle.

## Structure
- Shared package ps_pkg:
  - DATA_WIDTH.
  - FRAME_PIXELS.
  - Luma coefficients 5/9/2 and shift 4.
  - State enum {RUN, FLUSH}.
- One sub-module, ps_sync_fifo: a parameterized single-clock FIFO with synchronous active-high reset, a synchronous clear, registered read data, and the fill and flag outputs above. It is reusable by the other ps_ stages.

## Test plan
- Reset mid-stream:
  - Assert i_rst while 10 words are in flight.
  - Expected next cycle: o_rd=0, fill=0, empty=1, counter=0.
  - Expected after release: the first pixel out is the next upstream word.
- Threshold with i_enable=1, i_level=8:
  - Input 12'h888 gives Y=8 → 12'hFFF.
  - Input 12'h777 gives Y=7 → 12'h000.
  - Input 12'hF00 gives Y=4 → 12'h000.
  - Input 12'h0F0 gives Y=8 → 12'hFFF.
- Pass-through with i_enable=0: the ramp 12'h000..12'hFFF emerges bit-exact and in order at 1 pixel/cycle.
- Backpressure:
  - Never read the output FIFO.
  - Expected: fill stops at ≥1020 and ≤1024, full never overflows, o_rd=0 from the cycle almostfull asserts.
  - Then drain; o_rd resumes and no words are lost or duplicated.
- Flush:
  - Pulse i_flush for 3 cycles with fill=50 and one read in flight.
  - Expected: fill=0, the in-flight word is dropped, o_frame_done is not pulsed, and the counter restarts at 0.
- Frame boundary:
  - Stream 307200+5 pixels.
  - Expected: exactly one o_frame_done pulse, aligned with the write of pixel 307199; the counter then reads 5.
